decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage for the 32-bit, 5-bit-opcode core. It sits between instruction fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake.
- Splits the instruction into register, immediate and control fields and holds them in an output pipeline register.
- Detects load-use hazards against recently issued loads and inserts a programmable number of bubbles.
- Supports a synchronous flush for taken branches and jumps.

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/ins_decode.sv | 66 ++++++
 rtl/decode_stage.sv | 132 +++++++++++++
 tb/tb_decode_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 32-bit, 5-bit-opcode core: opcode values,
// instruction field positions and the decoded-instruction record.
package isa_pkg;

  localparam int FIELD_W = 5;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_J     = 5'b00001;
  localparam logic [FIELD_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [FIELD_W-1:0] OP_JAL   = 5'b00011;
  localparam logic [FIELD_W-1:0] OP_JR    = 5'b00100;
  localparam logic [FIELD_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [FIELD_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;
  localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FIELD_W-1:0] OP_SETX  = 5'b10101;
  localparam logic [FIELD_W-1:0] OP_BEX   = 5'b10110;

  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_MSB    = 16;

  // The record is sized for the widest supported datapath and PC; users
  // take the low XLEN / PC_W bits.
  localparam int XLEN_MAX = 64;
  localparam int PC_W_MAX = 27;

  typedef struct packed {
    logic [FIELD_W-1:0]  opcode;
    logic [FIELD_W-1:0]  rd;
    logic [FIELD_W-1:0]  rs;
    logic [FIELD_W-1:0]  rt;
    logic [FIELD_W-1:0]  shamt;
    logic [FIELD_W-1:0]  aluop;
    logic [XLEN_MAX-1:0] immediate;
    logic [PC_W_MAX-1:0] target;
    logic                we;
    logic                mwen;
    logic                lw;
    logic                use_rs;
    logic                use_rt;
    logic                use_rd;
  } decoded_t;

  function automatic logic [FIELD_W-1:0] field5(input logic [31:0] ins, input int lsb);
    return ins[lsb +: FIELD_W];
  endfunction

endpackage

// File: rtl/ins_decode.sv
// Combinational instruction splitter: fields, sign-extended immediate,
// jump target, control enables and register source-use flags.
module ins_decode
  import isa_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 12
) (
  input  logic [31:0] ins,
  output decoded_t    dec
);

  // Bits above XLEN / PC_W are forced to zero so the record never carries
  // information the stage cannot hold.
  localparam logic [XLEN_MAX-1:0] IMM_MASK =
    (XLEN >= XLEN_MAX) ? {XLEN_MAX{1'b1}} : ((XLEN_MAX'(1) << XLEN) - XLEN_MAX'(1));
  localparam logic [PC_W_MAX-1:0] TGT_MASK =
    (PC_W >= PC_W_MAX) ? {PC_W_MAX{1'b1}} : ((PC_W_MAX'(1) << PC_W) - PC_W_MAX'(1));

  // Field extraction and opcode-driven control / source-use decode.
  always_comb begin
    dec           = '0;
    dec.opcode    = field5(ins, OPCODE_LSB);
    dec.rd        = field5(ins, RD_LSB);
    dec.rs        = field5(ins, RS_LSB);
    dec.rt        = field5(ins, RT_LSB);
    dec.shamt     = field5(ins, SHAMT_LSB);
    dec.aluop     = field5(ins, ALUOP_LSB);
    dec.immediate = {{(XLEN_MAX-IMM_MSB-1){ins[IMM_MSB]}}, ins[IMM_MSB:0]} & IMM_MASK;
    dec.target    = ins[PC_W_MAX-1:0] & TGT_MASK;
    case (dec.opcode)
      OP_RTYPE: begin
        dec.we     = 1'b1;
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.we     = 1'b1;
        dec.use_rs = 1'b1;
      end
      OP_LW: begin
        dec.we     = 1'b1;
        dec.lw     = 1'b1;
        dec.use_rs = 1'b1;
      end
      OP_SW: begin
        dec.mwen   = 1'b1;
        dec.use_rs = 1'b1;
        dec.use_rd = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        dec.use_rs = 1'b1;
        dec.use_rd = 1'b1;
      end
      OP_JR: begin
        dec.use_rd = 1'b1;
      end
      OP_JAL, OP_SETX: begin
        dec.we = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// output pipeline register, load-use hazard tracker and branch flush.
//
// state | meaning
// RUN   | no pending load hit (cnt = 0 or no source matches ld_rd); accept when the output advances
// STALL | offered instruction reads ld_rd while cnt != 0; refuse it and issue bubbles until cnt = 0
//
// The two states are not stored: they are a pure function of cnt, ld_rd and
// the offered instruction, so the tracker registers are the only state.
module decode_stage
  import isa_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PC_W       = 12,
  parameter int LOAD_DELAY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_ins,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      shamt,
  output logic [4:0]      aluop,
  output logic [XLEN-1:0] immediate,
  output logic [PC_W-1:0] target,
  output logic            we,
  output logic            mwen,
  output logic            lw
);

  localparam logic [1:0] LD_CNT = 2'(LOAD_DELAY);

  decoded_t   dec;
  logic       adv;
  logic       src_hit;
  logic       stall;
  logic       xfer;
  logic [1:0] cnt;
  logic [4:0] ld_rd;
  logic       unused_dec_hi;

  ins_decode #(.XLEN(XLEN), .PC_W(PC_W)) u_ins_decode (
    .ins (in_ins),
    .dec (dec)
  );

  assign unused_dec_hi = ^{dec.immediate, dec.target};

  // Handshake: in_valid deliberately stays out of in_ready so fetch sees a
  // ready that does not depend on its own offer.
  always_comb begin
    adv     = ~out_valid | out_ready;
    src_hit = (dec.use_rs && (dec.rs != 5'd0) && (dec.rs == ld_rd)) ||
              (dec.use_rt && (dec.rt != 5'd0) && (dec.rt == ld_rd)) ||
              (dec.use_rd && (dec.rd != 5'd0) && (dec.rd == ld_rd));
    stall    = (cnt != 2'd0) && src_hit;
    in_ready = adv && !flush && !stall;
    xfer     = in_valid && in_ready;
  end

  // Hazard tracker: arm on an issued load, count down on every advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= 2'd0;
      ld_rd <= 5'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else if (adv) begin
      if (xfer && dec.lw && (dec.rd != 5'd0)) begin
        cnt   <= LD_CNT;
        ld_rd <= dec.rd;
      end else if (cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Valid and side-effect enables: cleared by flush, bubbles or reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      we        <= 1'b0;
      mwen      <= 1'b0;
      lw        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      we        <= 1'b0;
      mwen      <= 1'b0;
      lw        <= 1'b0;
    end else if (adv) begin
      out_valid <= xfer;
      we        <= xfer && dec.we;
      mwen      <= xfer && dec.mwen;
      lw        <= xfer && dec.lw;
    end
  end

  // Datapath fields only change on a real transfer; bubbles leave them be.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_pc    <= '0;
      opcode    <= 5'd0;
      rd        <= 5'd0;
      rs        <= 5'd0;
      rt        <= 5'd0;
      shamt     <= 5'd0;
      aluop     <= 5'd0;
      immediate <= '0;
      target    <= '0;
    end else if (xfer) begin
      out_pc    <= in_pc;
      opcode    <= dec.opcode;
      rd        <= dec.rd;
      rs        <= dec.rs;
      rt        <= dec.rt;
      shamt     <= dec.shamt;
      aluop     <= dec.aluop;
      immediate <= dec.immediate[XLEN-1:0];
      target    <= dec.target[PC_W-1:0];
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with LOAD_DELAY = 1 (_a) and
// one with LOAD_DELAY = 2 (_b), sharing all inputs.
module tb_decode_stage;

  localparam logic [31:0] ADDI_2_5_7 = 32'h288A_0007;
  localparam logic [31:0] ADDI_NEG   = 32'h2841_FFFF;
  localparam logic [31:0] LW_3       = 32'h40C0_0000;
  localparam logic [31:0] ADD_RS3    = 32'h0186_0000;
  localparam logic [31:0] ADD_RS4    = 32'h0188_0000;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [11:0] in_pc;
  logic [31:0] in_ins;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, we_a, mwen_a, lw_a;
  logic [11:0] out_pc_a, target_a;
  logic [4:0]  opcode_a, rd_a, rs_a, rt_a, shamt_a, aluop_a;
  logic [31:0] immediate_a;

  logic        in_ready_b, out_valid_b, we_b, mwen_b, lw_b;
  logic [11:0] out_pc_b, target_b;
  logic [4:0]  opcode_b, rd_b, rs_b, rt_b, shamt_b, aluop_b;
  logic [31:0] immediate_b;

  int n_chk;
  int n_fail;
  int bubbles;

  decode_stage #(.XLEN(32), .PC_W(12), .LOAD_DELAY(1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_pc(in_pc), .in_ins(in_ins),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
    .opcode(opcode_a), .rd(rd_a), .rs(rs_a), .rt(rt_a), .shamt(shamt_a), .aluop(aluop_a),
    .immediate(immediate_a), .target(target_a), .we(we_a), .mwen(mwen_a), .lw(lw_a)
  );

  decode_stage #(.XLEN(32), .PC_W(12), .LOAD_DELAY(2)) dut_b (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_pc(in_pc), .in_ins(in_ins),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_pc(out_pc_b),
    .opcode(opcode_b), .rd(rd_b), .rs(rs_b), .rt(rt_b), .shamt(shamt_b), .aluop(aluop_b),
    .immediate(immediate_b), .target(target_b), .we(we_b), .mwen(mwen_b), .lw(lw_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  // Issue lw r3 then a dependent candidate; count bubbles seen on one instance.
  task automatic load_use(input logic [31:0] dep, input bit use_b, output int nb);
    in_valid = 1'b1;
    in_ins   = LW_3;
    in_pc    = 12'h100;
    step();
    check("lu_lw_issued", use_b ? {31'd0, lw_b} : {31'd0, lw_a}, 32'd1);
    in_ins = dep;
    in_pc  = 12'h104;
    nb     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (use_b ? out_valid_b : out_valid_a) break;
      nb++;
    end
    in_valid = 1'b0;
    check("lu_dep_rd", use_b ? {27'd0, rd_b} : {27'd0, rd_a}, 32'd6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = 12'h000;
    in_ins    = 32'h0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_immediate", immediate_a, 32'd0);
    check("rst_we", {31'd0, we_a}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    repeat (2) step();
    reset = 1'b1;

    // Basic transfer.
    in_valid = 1'b1;
    in_ins   = ADDI_2_5_7;
    in_pc    = 12'h010;
    #1;
    check("basic_in_ready", {31'd0, in_ready_a}, 32'd1);
    step();
    check("basic_out_valid", {31'd0, out_valid_a}, 32'd1);
    check("basic_opcode", {27'd0, opcode_a}, 32'd5);
    check("basic_rd", {27'd0, rd_a}, 32'd2);
    check("basic_rs", {27'd0, rs_a}, 32'd5);
    check("basic_imm", immediate_a, 32'd7);
    check("basic_we", {31'd0, we_a}, 32'd1);
    check("basic_mwen", {31'd0, mwen_a}, 32'd0);
    check("basic_pc", {20'd0, out_pc_a}, 32'h010);
    check("basic_target", {20'd0, target_a}, 32'h007);
    check("basic_aluop", {27'd0, aluop_a}, 32'd1);

    // Negative immediate, back to back.
    in_ins = ADDI_NEG;
    in_pc  = 12'h014;
    step();
    check("neg_imm", immediate_a, 32'hFFFF_FFFF);
    check("neg_rd", {27'd0, rd_a}, 32'd1);
    check("neg_out_valid", {31'd0, out_valid_a}, 32'd1);
    idle(3);

    // Load-use hazards.
    load_use(ADD_RS3, 1'b0, bubbles);
    check("lu_delay1_bubbles", bubbles, 32'd1);
    idle(4);
    load_use(ADD_RS3, 1'b1, bubbles);
    check("lu_delay2_bubbles", bubbles, 32'd2);
    idle(4);
    load_use(ADD_RS4, 1'b0, bubbles);
    check("lu_indep_bubbles_a", bubbles, 32'd0);
    idle(4);
    load_use(ADD_RS4, 1'b1, bubbles);
    check("lu_indep_bubbles_b", bubbles, 32'd0);
    idle(4);

    // Backpressure with a pending load hazard.
    in_valid = 1'b1;
    in_ins   = LW_3;
    in_pc    = 12'h200;
    step();
    in_ins    = ADD_RS3;
    in_pc     = 12'h204;
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_held", {31'd0, in_ready_a}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
      check("bp_lw", {31'd0, lw_a}, 32'd1);
      check("bp_pc", {20'd0, out_pc_a}, 32'h200);
    end
    out_ready = 1'b1;
    #1;
    check("bp_cnt_not_decremented", {31'd0, in_ready_a}, 32'd0);
    step();
    check("bp_bubble", {31'd0, out_valid_a}, 32'd0);
    check("bp_ready_after_bubble", {31'd0, in_ready_a}, 32'd1);
    step();
    check("bp_dep_valid", {31'd0, out_valid_a}, 32'd1);
    check("bp_dep_rs", {27'd0, rs_a}, 32'd3);
    check("bp_dep_pc", {20'd0, out_pc_a}, 32'h204);
    in_valid = 1'b0;
    step();
    check("bp_no_duplicate", {31'd0, out_valid_a}, 32'd0);
    idle(4);

    // Flush during a LOAD_DELAY = 2 stall.
    in_valid = 1'b1;
    in_ins   = LW_3;
    in_pc    = 12'h300;
    step();
    in_ins = ADD_RS3;
    in_pc  = 12'h304;
    flush  = 1'b1;
    #1;
    check("fl_in_ready", {31'd0, in_ready_b}, 32'd0);
    step();
    check("fl_out_valid", {31'd0, out_valid_b}, 32'd0);
    check("fl_lw", {31'd0, lw_b}, 32'd0);
    check("fl_we", {31'd0, we_b}, 32'd0);
    flush = 1'b0;
    #1;
    check("fl_cnt_cleared", {31'd0, in_ready_b}, 32'd1);
    step();
    check("fl_dep_valid", {31'd0, out_valid_b}, 32'd1);
    check("fl_dep_rs", {27'd0, rs_b}, 32'd3);
    check("fl_dep_pc", {20'd0, out_pc_b}, 32'h304);
    idle(4);

    // Asynchronous reset between edges.
    in_valid = 1'b1;
    in_ins   = ADDI_2_5_7;
    in_pc    = 12'h400;
    step();
    check("mr_pre_valid", {31'd0, out_valid_a}, 32'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mr_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("mr_rd", {27'd0, rd_a}, 32'd0);
    check("mr_imm", immediate_a, 32'd0);
    check("mr_we", {31'd0, we_a}, 32'd0);
    check("mr_pc", {20'd0, out_pc_a}, 32'd0);
    #2;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_ins   = ADDI_NEG;
    in_pc    = 12'h404;
    step();
    check("mr_post_valid", {31'd0, out_valid_a}, 32'd1);
    check("mr_post_imm", immediate_a, 32'hFFFF_FFFF);
    check("mr_post_pc", {20'd0, out_pc_a}, 32'h404);
    in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
